demultiplexer_1to4_seq: RTL

DEMULTIPLEXER_1TO4_SEQ -- requirements
Module: demultiplexer_1to4_seq

---
 rtl/demultiplexer_1to4_seq_pkg.sv | 15 +
 rtl/demultiplexer_1to4_seq_sel_counter.sv | 29 ++
 rtl/demultiplexer_1to4_seq.sv | 87 ++++++++
 3 files changed

// File: rtl/demultiplexer_1to4_seq_pkg.sv
// demultiplexer_1to4_seq_pkg: shared lane index constants, the full-mask constant, and the lane one-hot helper.
// Optional feature macro used by this design: DEMUX_AUTO_SEL_EN (round-robin lane pointer).
package demultiplexer_1to4_seq_pkg;

    localparam logic [1:0] LANE0     = 2'd0;
    localparam logic [1:0] LANE1     = 2'd1;
    localparam logic [1:0] LANE2     = 2'd2;
    localparam logic [1:0] LANE3     = 2'd3;
    localparam logic [3:0] FULL_MASK = 4'b1111;

    function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/demultiplexer_1to4_seq_sel_counter.sv
// demux_sel_counter: 2-bit round-robin lane pointer, present only when DEMUX_AUTO_SEL_EN is defined.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset, pointer returns to LANE0
//   en    - advance the pointer by one lane (wraps 3 -> 0)
//   count - current lane pointer
`ifdef DEMUX_AUTO_SEL_EN
module demux_sel_counter
    import demultiplexer_1to4_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [1:0] count
);

    logic [1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst)
            r_count <= LANE0;
        else if (en)
            r_count <= r_count + 2'd1;
    end

    assign count = r_count;

endmodule
`endif

// File: rtl/demultiplexer_1to4_seq.sv
// demultiplexer_1to4_seq: registered 1-to-4 demultiplexer with per-write lane strobe and frame completion pulse.
// Macro DEMUX_AUTO_SEL_EN compiles in the round-robin pointer; otherwise auto_sel is ignored.
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   din, din_valid  - data word and its qualifier
//   s0, s1          - manual lane select {s1,s0}
//   auto_sel        - use the round-robin pointer instead of {s1,s0}
//   o0..o3          - registered lane outputs
//   lane_strobe     - one-hot of the lane written on the previous cycle
//   frame_valid     - pulse with the strobe of the write that completes all four lanes
module demultiplexer_1to4_seq
    import demultiplexer_1to4_seq_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             s0,
    input  logic             s1,
    input  logic             auto_sel,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2,
    output logic [WIDTH-1:0] o3,
    output logic [3:0]       lane_strobe,
    output logic             frame_valid
);

    logic [WIDTH-1:0] r_lane [4];
    logic [3:0]       r_strobe;
    logic [3:0]       r_mask;
    logic             r_frame;
    logic [1:0]       w_sel;
    logic [3:0]       w_hit;
    logic [3:0]       w_mask_next;
    logic             w_full;

`ifdef DEMUX_AUTO_SEL_EN
    logic [1:0] w_ptr;

    demux_sel_counter u_ptr (
        .clk   (clk),
        .rst   (rst),
        .en    (din_valid & auto_sel),
        .count (w_ptr)
    );

    assign w_sel = auto_sel ? w_ptr : {s1, s0};
`else
    logic w_unused_auto_sel;

    assign w_unused_auto_sel = auto_sel;
    assign w_sel = {s1, s0};
`endif

    assign w_hit       = lane_onehot(w_sel);
    assign w_mask_next = r_mask | w_hit;
    assign w_full      = (w_mask_next == FULL_MASK);

    // The completing write clears the mask on the same edge, so the very next
    // write starts a fresh frame without a dead cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane   <= '{default: '0};
            r_strobe <= 4'b0000;
            r_mask   <= 4'b0000;
            r_frame  <= 1'b0;
        end else begin
            r_strobe <= din_valid ? w_hit : 4'b0000;
            r_frame  <= din_valid && w_full;
            if (din_valid) begin
                r_lane[w_sel] <= din;
                r_mask        <= w_full ? 4'b0000 : w_mask_next;
            end
        end
    end

    assign o0          = r_lane[LANE0];
    assign o1          = r_lane[LANE1];
    assign o2          = r_lane[LANE2];
    assign o3          = r_lane[LANE3];
    assign lane_strobe = r_strobe;
    assign frame_valid = r_frame;

endmodule
